// File: rtl/phy_strp_pkg.sv
// Shared types and constants for the 32-to-8 byte serializer word path.
package phy_strp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } strp_state_t;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/strp_word_sched_rr_arbiter.sv
// Combinational round-robin arbiter with an owner-continuation bypass.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               hold_owner,
    input  logic [IDX_W-1:0]   owner,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   winner,
    output logic               found
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        if (hold_owner && req[owner]) begin
            winner = owner;
            found  = 1'b1;
        end else begin
            // First requester at or above the pointer, wrapping past NUM_REQ-1.
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
                if (!found && req[cand]) begin
                    winner = cand;
                    found  = 1'b1;
                end
            end
        end
        if (found)
            grant[winner] = 1'b1;
    end

endmodule

// File: rtl/strp_word_sched.sv
// Round-robin word scheduler feeding the 32-to-8 serializer; each word is held for 4 byte slots.
// Optional macro STRP_IDLE_FILL_EN: keep valid_strp high with IDLE_WORD when no source is ready.
module strp_word_sched
    import phy_strp_pkg::*;
#(
    parameter int          NUM_REQ   = 4,
    parameter int          BURST_LEN = 4,
    parameter logic [31:0] IDLE_WORD = 32'h00000000,
    parameter int          IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                  clk_4f,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [31:0]           data_strp,
    output logic                  valid_strp,
    output logic [IDX_W-1:0]      grant_id,
    output logic [1:0]            phase
);

    localparam logic [1:0] LAST_PHASE = 2'(BYTES_PER_WORD - 1);

    strp_state_t      state;
    logic [3:0]       burst_cnt;
    logic [IDX_W-1:0] rr_ptr;

    logic               pop_slot;
    logic               hold_owner;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   winner;
    logic               found;
    logic [WORD_W-1:0]  words [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            words[i] = req_data[WORD_W*i +: WORD_W];
    end

    assign pop_slot = (state == IDLE) || (phase == LAST_PHASE);
    // A zero burst count marks "no real owner", so an idle-fill word never continues.
    assign hold_owner = (state == SEND) && (burst_cnt != 4'd0) &&
                        (burst_cnt < 4'(BURST_LEN));

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req_valid),
        .ptr        (rr_ptr),
        .hold_owner (hold_owner),
        .owner      (grant_id),
        .grant      (grant),
        .winner     (winner),
        .found      (found)
    );

    assign req_ready = (reset && pop_slot) ? grant : '0;

    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            state      <= IDLE;
            valid_strp <= 1'b0;
            data_strp  <= '0;
            phase      <= 2'd0;
            grant_id   <= '0;
            rr_ptr     <= '0;
            burst_cnt  <= 4'd0;
        end else if (pop_slot) begin
            phase <= 2'd0;
            if (found) begin
                state      <= SEND;
                valid_strp <= 1'b1;
                data_strp  <= words[winner];
                grant_id   <= winner;
                if (hold_owner && winner == grant_id) begin
                    burst_cnt <= burst_cnt + 4'd1;
                end else begin
                    burst_cnt <= 4'd1;
                    rr_ptr    <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                end
            end else begin
                burst_cnt <= 4'd0;
`ifdef STRP_IDLE_FILL_EN
                state      <= SEND;
                valid_strp <= 1'b1;
                data_strp  <= IDLE_WORD;
                grant_id   <= '0;
`else
                state      <= IDLE;
                valid_strp <= 1'b0;
`endif
            end
        end else begin
            phase <= phase + 2'd1;
        end
    end

endmodule

// File: tb/tb_strp_word_sched.sv
// Randomized bench for strp_word_sched against a slot-level reference model.
module tb_strp_word_sched;

    localparam int          NR = 4;
    localparam int          BL = 2;
    localparam logic [31:0] IW = 32'hBCBCBCBC;

    logic              clk_4f = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [32*NR-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic [31:0]       data_strp;
    logic              valid_strp;
    logic [1:0]        grant_id;
    logic [1:0]        phase;

    always #5 clk_4f = ~clk_4f;

    strp_word_sched #(
        .NUM_REQ   (NR),
        .BURST_LEN (BL),
        .IDLE_WORD (IW)
    ) dut (
        .clk_4f     (clk_4f),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .data_strp  (data_strp),
        .valid_strp (valid_strp),
        .grant_id   (grant_id),
        .phase      (phase)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a word is "on the wire" for slots 0..3; m_busy says a word stream is active.
    bit          m_busy  = 0;
    bit          m_valid = 0;
    int          m_slot  = 0;
    logic [31:0] m_data  = '0;
    int          m_owner = 0;
    int          m_run   = 0;
    int          m_next  = 0;

    function automatic bit owner_may_continue();
        return m_busy && m_run > 0 && m_run < BL && req_valid[m_owner];
    endfunction

    function automatic int choose();
        if (owner_may_continue())
            return m_owner;
        for (int k = 0; k < NR; k++)
            if (req_valid[(m_next + k) % NR])
                return (m_next + k) % NR;
        return -1;
    endfunction

    task automatic cycle(input int dens, input logic [NR-1:0] mask,
                         input bit rnd_rst, input bit force_rst);
        int          w;
        bit          cont;
        bit          pop;
        logic [NR-1:0] exp_ready;

        check_val("valid_strp", {31'd0, valid_strp}, {31'd0, m_valid});
        check_val("data_strp", data_strp, m_data);
        check_val("phase", {30'd0, phase}, 32'(m_slot));
        check_val("grant_id", {30'd0, grant_id}, 32'(m_owner));

        reset = !(force_rst || (rnd_rst && $urandom_range(0, 149) == 0));
        for (int i = 0; i < NR; i++) begin
            req_valid[i]       = mask[i] && ($urandom_range(0, 99) < dens);
            req_data[32*i +: 32] = $urandom;
        end

        @(negedge clk_4f);
        pop       = !m_busy || m_slot == 3;
        cont      = owner_may_continue();
        w         = choose();
        exp_ready = '0;
        if (reset && pop && w >= 0)
            exp_ready[w] = 1'b1;
        check_val("req_ready", {28'd0, req_ready}, {28'd0, exp_ready});

        if (!reset) begin
            m_busy = 0; m_valid = 0; m_slot = 0; m_data = '0;
            m_owner = 0; m_run = 0; m_next = 0;
        end else if (pop) begin
            m_slot = 0;
            if (w >= 0) begin
                m_data  = req_data[32*w +: 32];
                m_valid = 1;
                m_busy  = 1;
                if (cont && w == m_owner) begin
                    m_run++;
                end else begin
                    m_run  = 1;
                    m_next = (w + 1) % NR;
                end
                m_owner = w;
            end else begin
                m_run = 0;
`ifdef STRP_IDLE_FILL_EN
                m_valid = 1; m_busy = 1; m_data = IW; m_owner = 0;
`else
                m_valid = 0; m_busy = 0;
`endif
            end
        end else begin
            m_slot++;
        end

        @(posedge clk_4f);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        repeat (2) @(posedge clk_4f);
        #1;
        m_busy = 0; m_valid = 0; m_slot = 0; m_data = '0;
        m_owner = 0; m_run = 0; m_next = 0;

        repeat (2)   cycle(0,   4'b1111, 0, 1);
        repeat (200) cycle(100, 4'b1111, 0, 0);
        repeat (300) cycle(50,  4'b1111, 0, 0);
        repeat (200) cycle(30,  4'b0010, 0, 0);
        repeat (200) cycle(100, 4'b1001, 0, 0);
        repeat (400) cycle(70,  4'b1111, 1, 0);
        repeat (300) cycle(10,  4'b1111, 1, 0);
        repeat (2)   cycle(0,   4'b1111, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/strp_word_sched.md
Name: strp_word_sched

Overview:
- Round-robin scheduler that shares the 32-to-8 byte serializer stage among NUM_REQ 32-bit word sources. Typical sources are ordered-set generators and the TLP/DLLP data path.
- Presents one word on data_strp/valid_strp and holds it stable for exactly 4 clk_4f cycles, one per byte slot.
- Pops the next word on the 4th slot, so the serializer receives back-to-back words with no bubble.
- Sits between the source FIFOs and the serializer, in the clk_4f domain.

Parameters:
- NUM_REQ, 4, number of requesting sources (2..8).
- BURST_LEN, 4, maximum consecutive words granted to one source before re-arbitration (1..15).
- IDLE_WORD, 32'h00000000, word driven while idle (used only with STRP_IDLE_FILL_EN).

Ports:
- clk_4f  in  1  byte-rate clock.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  source i has a word available.
- req_data  in  32*NUM_REQ  word of source i, in bits [32*i+31:32*i].
- req_ready  out  NUM_REQ  combinational pop strobe; a transfer occurs when req_valid[i] & req_ready[i].
- data_strp  out  32  word to the serializer, registered.
- valid_strp  out  1  word valid to the serializer, registered.
- grant_id  out  clog2(NUM_REQ)  owner of the current word, registered.
- phase  out  2  byte slot of the current word (0..3), registered.

Behaviour:
- Reset (reset==0 at a clk_4f edge):
  - State goes to IDLE.
  - valid_strp=0, data_strp=0, phase=0, grant_id=0.
  - Round-robin pointer=0, burst counter=0.
  - req_ready is forced to 0 combinationally while reset==0.
  - Reset mid-word abandons the word. No source is re-popped, so the word is lost.
- States: IDLE and SEND.
- Pop slot: the cycle where state==IDLE, or where state==SEND and phase==3. req_ready is only ever asserted in a pop slot.
- Arbitration in a pop slot:
  - The current owner continues if it is in SEND, its req_valid is 1, and burst count < BURST_LEN.
  - Otherwise the first requester with req_valid=1 is chosen, searching from the pointer upward with wrap-around.
  - At most one req_ready bit is high, and only for a requester whose req_valid=1.
- On a pop at edge t:
  - data_strp takes the popped word, valid_strp=1, phase=0, grant_id=winner.
  - Burst counter becomes count+1 on continuation, or 1 on a new grant.
  - On a new grant, the pointer becomes winner+1 mod NUM_REQ.
- In SEND with phase!=3: phase increments by 1, and data_strp and grant_id hold.
- Pop slot with no requester valid:
  - State goes to IDLE, valid_strp=0, phase=0, burst counter=0.
  - data_strp is held. The serializer resets its byte selector when valid_strp is 0.
- Latency: a word appears on data_strp 1 cycle after its pop cycle. Each word occupies exactly 4 cycles of valid_strp=1.
- Sustained throughput is 1 word per 4 cycles. A source whose req_valid stays high is never starved: it waits at most (NUM_REQ-1)*BURST_LEN words.
- req_valid dropping in a non-pop slot has no effect.
- req_data must be stable only during the pop cycle.

Optional Feature:
- Macro: STRP_IDLE_FILL_EN.
- Defined: a pop slot with no requester keeps valid_strp=1, loads IDLE_WORD into data_strp, keeps phase cycling, and sets grant_id=0. The serializer byte phase is never broken; IDLE is entered only from reset.
- Undefined: behaviour as described above (valid_strp drops to 0).

Decomposition:
- Shared package phy_strp_pkg holds:
  - strp_state_t enum {IDLE, SEND}.
  - Constant WORD_W=32.
  - Constant BYTES_PER_WORD=4.
- One natural sub-module: rr_arbiter. It takes req, pointer, and hold_owner/owner inputs and returns the one-hot grant plus the winner index. It is purely combinational.

Test Plan:
- Single source: NUM_REQ=4, only req 2 valid with words A1B2C3D4 then 11223344.
  - ready[2] pulses at cycle 0 and cycle 4.
  - valid_strp=1 for 8 cycles, phase sequence 0,1,2,3,0,1,2,3, data_strp switches at cycle 5.
- All four sources continuously valid, BURST_LEN=2: grant_id sequence 0,0,1,1,2,2,3,3,0 with each word held 4 cycles, and no valid_strp gap.
- Source 1 drops req_valid after one word with no other requester:
  - After phase 3, valid_strp=0 and state is IDLE.
  - Source 1 re-asserts → pop in the same cycle, valid_strp=1 the next cycle at phase 0.
- Reset pulled low at phase 2 of word DEADBEEF: the next cycle has valid_strp=0, data_strp=0, phase=0, and no req_ready asserted while reset is low.
- Requesters 0 and 3 both valid, pointer=1 → 3 wins. The next new grant goes to 0 (wrap-around).
- With STRP_IDLE_FILL_EN and IDLE_WORD=BCBCBCBC, a source runs dry → valid_strp stays 1, data_strp=BCBCBCBC, and phase keeps cycling.
